// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the pipelined_mips memory side.
// Holds the data-memory responder state set and line alignment.
package mips_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RWAIT,
      RBURST,
      WBURST,
      WWAIT
   } dmem_state_t;

   localparam int DMEM_LINE_WORDS = 4;
   localparam int DMEM_WORD_BYTES = 4;

   // Word index of the first word of the line holding addr.
   function automatic logic [29:0] line_base(
      input logic [31:0] addr,
      input int unsigned words = DMEM_LINE_WORDS
   );
      logic [29:0] w_mask;
      logic [29:0] w_word;
      w_mask = 30'(words - 1);
      w_word = 30'(addr / DMEM_WORD_BYTES);
      return w_word & ~w_mask;
   endfunction

endpackage

// File: rtl/dmem_lat_cnt.sv
// Loadable down-counter that parks at zero.
// Shared by the refill and writeback latency waits.
module dmem_lat_cnt #(
   parameter int W = 3
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dmem_line_responder.sv
// Data-cache line responder: refill and writeback bursts
// against a word array with a fixed access latency.
module dmem_line_responder
   import mips_mem_pkg::*;
#(
   parameter int LINE_WORDS = DMEM_LINE_WORDS,
   parameter int MEM_WORDS  = 1024,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic        wr_valid,
   input  logic [31:0] wr_data,
   output logic        wr_done,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        rd_last
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int BW = $clog2(LINE_WORDS);
   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
   localparam logic [CW-1:0] LAT_LOAD  = CW'(LATENCY - 1);

   logic [31:0] mem_data [MEM_WORDS];

   dmem_state_t   r_state;
   logic [BW-1:0] r_beat;
   logic [AW-1:0] r_base;
   logic          r_req_ready;
   logic          r_rd_valid;
   logic          r_rd_last;
   logic [31:0]   r_rd_data;
   logic          r_wr_done;

   logic [29:0]   w_base;
   logic [AW-1:0] w_idx;
   logic          w_accept;
   logic          w_last;
   logic          w_wbeat;
   logic          w_load;
   logic          w_zero;
   logic          w_unused;

   assign w_base   = line_base(req_addr, LINE_WORDS);
   assign w_unused = ^w_base[29:AW];
   assign w_idx    = r_base + AW'(r_beat);
   assign w_accept = (r_state == IDLE) && r_req_ready && req_valid;
   assign w_last   = (r_beat == LAST_BEAT);
   assign w_wbeat  = (r_state == WBURST) && wr_valid;
   assign w_load   = (w_accept && !req_write) || (w_wbeat && w_last);

   dmem_lat_cnt #(
      .W (CW)
   ) u_lat (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_load  (w_load),
      .i_val   (LAT_LOAD),
      .o_zero  (w_zero)
   );

   // Ready comes back one cycle after re-entering IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_beat      <= '0;
         r_base      <= '0;
         r_req_ready <= 1'b1;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_rd_data   <= '0;
         r_wr_done   <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_wr_done  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_base      <= w_base[AW-1:0];
                  r_beat      <= '0;
                  r_state     <= req_write ? WBURST : RWAIT;
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            RWAIT: begin
               if (w_zero) begin
                  r_rd_valid <= 1'b1;
                  r_rd_data  <= mem_data[w_idx];
                  r_beat     <= r_beat + 1'b1;
                  r_state    <= RBURST;
               end
            end
            RBURST: begin
               r_rd_valid <= 1'b1;
               r_rd_data  <= mem_data[w_idx];
               r_beat     <= r_beat + 1'b1;
               if (w_last) begin
                  r_rd_last <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            WBURST: begin
               if (wr_valid) begin
                  r_beat <= r_beat + 1'b1;
                  if (w_last) begin
                     r_state <= WWAIT;
                  end
               end
            end
            WWAIT: begin
               if (w_zero) begin
                  r_wr_done <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Backing store is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (w_wbeat) begin
         mem_data[w_idx] <= wr_data;
      end
   end

   assign req_ready = r_req_ready;
   assign rd_valid  = r_rd_valid;
   assign rd_last   = r_rd_last;
   assign rd_data   = r_rd_data;
   assign wr_done   = r_wr_done;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder (LINE_WORDS=4,
// MEM_WORDS=1024, LATENCY=4).
module tb_dmem_line_responder;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_done;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_last;

   int n_checks;
   int n_fail;

   dmem_line_responder dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_done   (wr_done),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept at T0; beats on cycles T0+4..T0+7, ready at T0+8.
   task automatic do_refill(input logic [31:0] addr,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input int pulse_k, input string tag);
      logic [31:0] ed [4];
      logic        ev;
      ed[0] = e0; ed[1] = e1; ed[2] = e2; ed[3] = e3;
      chk({tag, "_ready_pre"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = addr;
      tick();
      req_valid = 1'b0;
      chk({tag, "_ready_t0"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_valid_t0"}, {31'd0, rd_valid}, 32'd0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         ev = (k >= 4) && (k <= 7);
         chk($sformatf("%s_valid_k%0d", tag, k), {31'd0, rd_valid},
             {31'd0, ev});
         if (ev) begin
            chk($sformatf("%s_data_k%0d", tag, k), rd_data, ed[k-4]);
         end
         chk($sformatf("%s_last_k%0d", tag, k), {31'd0, rd_last},
             {31'd0, k == 7});
         chk($sformatf("%s_ready_k%0d", tag, k), {31'd0, req_ready},
             {31'd0, k == 8});
         req_valid = (k == pulse_k);
      end
   endtask

   // stall_after = beats sent before a gap of stall_len idle cycles.
   task automatic do_wb(input logic [31:0] addr,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input int stall_after, input int stall_len,
                        input string tag);
      logic [31:0] ed [4];
      ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
      chk({tag, "_ready_pre"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = addr;
      tick();
      req_valid = 1'b0;
      req_write = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (b == stall_after) begin
            for (int s = 0; s < stall_len; s++) begin
               wr_valid = 1'b0;
               tick();
               chk($sformatf("%s_stall_ready%0d", tag, s),
                   {31'd0, req_ready}, 32'd0);
               chk($sformatf("%s_stall_done%0d", tag, s),
                   {31'd0, wr_done}, 32'd0);
            end
         end
         wr_valid = 1'b1;
         wr_data  = ed[b];
         tick();
         chk($sformatf("%s_beat_ready%0d", tag, b),
             {31'd0, req_ready}, 32'd0);
      end
      wr_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk($sformatf("%s_done_k%0d", tag, k), {31'd0, wr_done},
             {31'd0, k == 4});
         chk($sformatf("%s_ready_k%0d", tag, k), {31'd0, req_ready},
             {31'd0, k == 5});
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;

      // Reset state
      tick();
      tick();
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
      chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      reset = 1'b1;
      tick();

      // 1: refill of preloaded line
      for (int i = 0; i < 4; i++) dut.mem_data[32+i] = 32'hA0 + 32'(i);
      do_refill(32'h80, 32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, "rf1");

      // 2: writeback at unaligned 0x84 with a 3-cycle stall
      do_wb(32'h84, 32'h11, 32'h22, 32'h33, 32'h44, 2, 3, "wb2");
      chk("wb2_mem32", dut.mem_data[32], 32'h11);
      chk("wb2_mem33", dut.mem_data[33], 32'h22);
      chk("wb2_mem34", dut.mem_data[34], 32'h33);
      chk("wb2_mem35", dut.mem_data[35], 32'h44);

      // 6: req_valid pulse during RBURST, wr_valid pulse in IDLE
      do_refill(32'h80, 32'h11, 32'h22, 32'h33, 32'h44, 5, "ign");
      wr_valid = 1'b1;
      wr_data  = 32'hBAD0BAD0;
      tick();
      wr_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("ign_no_burst%0d", k), {31'd0, rd_valid}, 32'd0);
      end
      chk("ign_ready", {31'd0, req_ready}, 32'd1);
      chk("ign_mem32", dut.mem_data[32], 32'h11);
      chk("ign_mem33", dut.mem_data[33], 32'h22);
      chk("ign_mem34", dut.mem_data[34], 32'h33);
      chk("ign_mem35", dut.mem_data[35], 32'h44);

      // 3: back-to-back writeback then refill of 0x200
      do_wb(32'h200, 32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003,
            32'h5A5A0004, -1, 0, "b2b_wb");
      do_refill(32'h200, 32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003,
                32'h5A5A0004, -1, "b2b_rf");

      // 4: address wrap 0x1000 -> index 0
      for (int i = 0; i < 4; i++) dut.mem_data[i] = 32'hC0 + 32'(i);
      do_refill(32'h1000, 32'hC0, 32'hC1, 32'hC2, 32'hC3, -1, "wrap");

      // 5: reset after 2 of 4 writeback beats
      for (int i = 0; i < 4; i++) begin
         dut.mem_data[64+i] = 32'hDEAD0000 + 32'(i);
      end
      chk("mr_ready_pre", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h100;
      tick();
      req_valid = 1'b0;
      req_write = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 32'h55;
      tick();
      wr_data   = 32'h66;
      tick();
      wr_data   = 32'h77;
      #2;
      reset = 1'b0;
      #1;
      chk("mr_async_ready", {31'd0, req_ready}, 32'd1);
      chk("mr_async_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("mr_async_rd_last", {31'd0, rd_last}, 32'd0);
      chk("mr_async_wr_done", {31'd0, wr_done}, 32'd0);
      chk("mr_async_rd_data", rd_data, 32'd0);
      tick();
      reset    = 1'b1;
      wr_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("mr_no_done%0d", k), {31'd0, wr_done}, 32'd0);
      end
      chk("mr_ready_post", {31'd0, req_ready}, 32'd1);
      chk("mr_mem64", dut.mem_data[64], 32'h55);
      chk("mr_mem65", dut.mem_data[65], 32'h66);
      chk("mr_mem66", dut.mem_data[66], 32'hDEAD0002);
      chk("mr_mem67", dut.mem_data[67], 32'hDEAD0003);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
